// File: rtl/axi4_slave_sram_if.sv
// AXI4 memory-channel bundle between the core (master) and the SRAM slave.
// It carries the AW, W, B, AR and R channels with DW-bit data.
interface axi4_slave_sram_if #(parameter int DW = 128);
  logic [31:0]     MEM_AWADDR;
  logic [7:0]      MEM_AWLEN;
  logic [2:0]      MEM_AWSIZE;
  logic [1:0]      MEM_AWBURST;
  logic            MEM_AWVALID;
  logic            MEM_AWREADY;
  logic [DW-1:0]   MEM_WDATA;
  logic [DW/8-1:0] MEM_WSTRB;
  logic            MEM_WLAST;
  logic            MEM_WVALID;
  logic            MEM_WREADY;
  logic [1:0]      MEM_BRESP;
  logic            MEM_BVALID;
  logic            MEM_BREADY;
  logic [31:0]     MEM_ARADDR;
  logic [7:0]      MEM_ARLEN;
  logic [2:0]      MEM_ARSIZE;
  logic [1:0]      MEM_ARBURST;
  logic            MEM_ARVALID;
  logic            MEM_ARREADY;
  logic [DW-1:0]   MEM_RDATA;
  logic [1:0]      MEM_RRESP;
  logic            MEM_RLAST;
  logic            MEM_RVALID;
  logic            MEM_RREADY;

  modport slave (
    input  MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST, MEM_AWVALID,
    output MEM_AWREADY,
    input  MEM_WDATA, MEM_WSTRB, MEM_WLAST, MEM_WVALID,
    output MEM_WREADY,
    output MEM_BRESP, MEM_BVALID,
    input  MEM_BREADY,
    input  MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST, MEM_ARVALID,
    output MEM_ARREADY,
    output MEM_RDATA, MEM_RRESP, MEM_RLAST, MEM_RVALID,
    input  MEM_RREADY
  );

  modport master (
    output MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST, MEM_AWVALID,
    input  MEM_AWREADY,
    output MEM_WDATA, MEM_WSTRB, MEM_WLAST, MEM_WVALID,
    input  MEM_WREADY,
    input  MEM_BRESP, MEM_BVALID,
    output MEM_BREADY,
    output MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST, MEM_ARVALID,
    input  MEM_ARREADY,
    input  MEM_RDATA, MEM_RRESP, MEM_RLAST, MEM_RVALID,
    output MEM_RREADY
  );
endinterface

// File: rtl/axi4_slave_sram.sv
// AXI4 full slave over a byte-writable SRAM. Independent write and read FSMs
// share one array. The read port is registered, so a same-edge collision returns old data.
module axi4_slave_sram_mem #(
  parameter int DW = 128,
  parameter int IW = 14
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [IW-1:0]   widx,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            re,
  input  logic [IW-1:0]   ridx,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] ram [0:(2**IW)-1];
  logic [DW-1:0] rdata_r;

  // Byte-lane write; contents are intentionally never reset
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wstrb[b]) begin
          ram[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read port, cleared by reset so RDATA starts at 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= ram[ridx];
    end
  end

  assign rdata = rdata_r;
endmodule

module axi4_slave_sram #(
  parameter int DW = 128,
  parameter int AW = 16
) (
  input logic          clock,
  input logic          reset,
  axi4_slave_sram_if.slave mem
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = AW - 2;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t w_state_r, w_state_nx_s;
  r_state_t r_state_r, r_state_nx_s;

  logic        awready_r, wready_r, bvalid_r, arready_r, rvalid_r, rlast_r;
  logic [31:0] waddr_r, raddr_r;
  logic [7:0]  wlen_r, rlen_r, wbeat_r, rbeat_r;
  logic [2:0]  wsize_r, rsize_r;
  logic [1:0]  wburst_r, rburst_r;

  logic        aw_hs_s, w_hs_s, w_done_s, b_hs_s;
  logic        ar_hs_s, r_hs_s, r_done_s, rd_en_s;
  logic [31:0] rd_addr_s;
  logic [DW-1:0] rdata_s;

  // FIXED holds, WRAP folds into the (len+1)*2^size window, INCR and reserved step forward
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'd0:    next_addr = addr;
      2'd2:    next_addr = (addr & ~mask) | ((addr + step) & mask);
      default: next_addr = addr + step;
    endcase
  endfunction

  assign aw_hs_s  = mem.MEM_AWVALID & awready_r;
  assign w_hs_s   = mem.MEM_WVALID & wready_r;
  assign w_done_s = w_hs_s & (mem.MEM_WLAST | (wbeat_r == wlen_r));
  assign b_hs_s   = bvalid_r & mem.MEM_BREADY;
  assign ar_hs_s  = mem.MEM_ARVALID & arready_r;
  assign r_hs_s   = rvalid_r & mem.MEM_RREADY;
  assign r_done_s = r_hs_s & rlast_r;

  // Write channel next-state
  always_comb begin
    w_state_nx_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_hs_s)  w_state_nx_s = W_DATA; else w_state_nx_s = W_IDLE;
      W_DATA:  if (w_done_s) w_state_nx_s = W_RESP; else w_state_nx_s = W_DATA;
      W_RESP:  if (b_hs_s)   w_state_nx_s = W_IDLE; else w_state_nx_s = W_RESP;
      default: w_state_nx_s = W_IDLE;
    endcase
  end

  // Read channel next-state and SRAM read request for the beat shown next
  always_comb begin
    r_state_nx_s = r_state_r;
    rd_en_s      = 1'b0;
    rd_addr_s    = raddr_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_nx_s = R_DATA;
          rd_en_s      = 1'b1;
          rd_addr_s    = mem.MEM_ARADDR;
        end else begin
          r_state_nx_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (r_done_s) begin
          r_state_nx_s = R_IDLE;
        end else if (r_hs_s) begin
          rd_en_s   = 1'b1;
          rd_addr_s = next_addr(raddr_r, rlen_r, rsize_r, rburst_r);
        end else begin
          r_state_nx_s = R_DATA;
        end
      end
      default: r_state_nx_s = R_IDLE;
    endcase
  end

  // State registers; handshake outputs follow the state being entered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_r <= W_IDLE;
      r_state_r <= R_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_state_nx_s;
      r_state_r <= r_state_nx_s;
      awready_r <= (w_state_nx_s == W_IDLE);
      wready_r  <= (w_state_nx_s == W_DATA);
      bvalid_r  <= (w_state_nx_s == W_RESP);
      arready_r <= (r_state_nx_s == R_IDLE);
      rvalid_r  <= (r_state_nx_s == R_DATA);
    end
  end

  // Write burst parameters, current address and beat count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      waddr_r  <= 32'd0;
      wlen_r   <= 8'd0;
      wsize_r  <= 3'd0;
      wburst_r <= 2'd0;
      wbeat_r  <= 8'd0;
    end else if (aw_hs_s) begin
      waddr_r  <= mem.MEM_AWADDR;
      wlen_r   <= mem.MEM_AWLEN;
      wsize_r  <= mem.MEM_AWSIZE;
      wburst_r <= mem.MEM_AWBURST;
      wbeat_r  <= 8'd0;
    end else if (w_hs_s) begin
      waddr_r  <= next_addr(waddr_r, wlen_r, wsize_r, wburst_r);
      wbeat_r  <= wbeat_r + 8'd1;
    end
  end

  // Read burst parameters; raddr_r always tracks the beat currently presented
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raddr_r  <= 32'd0;
      rlen_r   <= 8'd0;
      rsize_r  <= 3'd0;
      rburst_r <= 2'd0;
      rbeat_r  <= 8'd0;
      rlast_r  <= 1'b0;
    end else if (ar_hs_s) begin
      raddr_r  <= mem.MEM_ARADDR;
      rlen_r   <= mem.MEM_ARLEN;
      rsize_r  <= mem.MEM_ARSIZE;
      rburst_r <= mem.MEM_ARBURST;
      rbeat_r  <= 8'd0;
      rlast_r  <= (mem.MEM_ARLEN == 8'd0);
    end else if (r_done_s) begin
      rlast_r  <= 1'b0;
    end else if (r_hs_s) begin
      raddr_r  <= rd_addr_s;
      rbeat_r  <= rbeat_r + 8'd1;
      rlast_r  <= ((rbeat_r + 8'd1) == rlen_r);
    end
  end

  axi4_slave_sram_mem #(.DW(DW), .IW(IW)) i_sram (
    .clock (clock),
    .reset (reset),
    .we    (w_hs_s),
    .widx  (waddr_r[LB +: IW]),
    .wdata (mem.MEM_WDATA),
    .wstrb (mem.MEM_WSTRB),
    .re    (rd_en_s),
    .ridx  (rd_addr_s[LB +: IW]),
    .rdata (rdata_s)
  );

  assign mem.MEM_AWREADY = awready_r;
  assign mem.MEM_WREADY  = wready_r;
  assign mem.MEM_BRESP   = 2'b00;
  assign mem.MEM_BVALID  = bvalid_r;
  assign mem.MEM_ARREADY = arready_r;
  assign mem.MEM_RDATA   = rdata_s;
  assign mem.MEM_RRESP   = 2'b00;
  assign mem.MEM_RLAST   = rlast_r;
  assign mem.MEM_RVALID  = rvalid_r;
endmodule

// File: tb/tb_axi4_slave_sram.sv
// Directed bench for axi4_slave_sram: reset, backdoor read, INCR/WRAP/FIXED bursts,
// strobes, backpressure, concurrent channels and mid-burst reset.
module tb_axi4_slave_sram;
  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [127:0] wbuf [0:15];
  logic [127:0] rbuf [0:15];
  logic         rlb  [0:15];

  axi4_slave_sram_if #(.DW(128)) mem ();

  axi4_slave_sram #(.DW(128), .AW(16)) dut (
    .clock (clock),
    .reset (reset),
    .mem   (mem.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [15:0] strb);
    int k;
    mem.MEM_AWADDR  = addr;
    mem.MEM_AWLEN   = len;
    mem.MEM_AWSIZE  = 3'd4;
    mem.MEM_AWBURST = 2'd1;
    mem.MEM_AWVALID = 1'b1;
    k = 0;
    while (!mem.MEM_AWREADY && k < 50) begin tick(); k++; end
    check_val("aw_ready_wait", 128'(k < 50), 128'(1));
    tick();
    mem.MEM_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      mem.MEM_WDATA  = wbuf[i];
      mem.MEM_WSTRB  = strb;
      mem.MEM_WLAST  = (i == int'(len));
      mem.MEM_WVALID = 1'b1;
      k = 0;
      while (!mem.MEM_WREADY && k < 50) begin tick(); k++; end
      tick();
    end
    mem.MEM_WVALID = 1'b0;
    mem.MEM_WLAST  = 1'b0;
    mem.MEM_BREADY = 1'b1;
    k = 0;
    while (!mem.MEM_BVALID && k < 50) begin tick(); k++; end
    check_val("bvalid", 128'(mem.MEM_BVALID), 128'(1));
    check_val("bresp", 128'(mem.MEM_BRESP), 128'(0));
    tick();
    mem.MEM_BREADY = 1'b0;
    check_val("bvalid_drop", 128'(mem.MEM_BVALID), 128'(0));
    check_val("awready_back", 128'(mem.MEM_AWREADY), 128'(1));
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input bit toggle);
    int k;
    int n;
    int cyc;
    logic [127:0] held;
    logic         heldl;
    mem.MEM_ARADDR  = addr;
    mem.MEM_ARLEN   = len;
    mem.MEM_ARSIZE  = 3'd4;
    mem.MEM_ARBURST = burst;
    mem.MEM_ARVALID = 1'b1;
    k = 0;
    while (!mem.MEM_ARREADY && k < 50) begin tick(); k++; end
    tick();
    mem.MEM_ARVALID = 1'b0;
    n = 0;
    cyc = 0;
    while (n <= int'(len) && cyc < 200) begin
      mem.MEM_RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
      if (mem.MEM_RVALID && !mem.MEM_RREADY) begin
        held  = mem.MEM_RDATA;
        heldl = mem.MEM_RLAST;
        tick();
        check_val("rd_hold_data", mem.MEM_RDATA, held);
        check_val("rd_hold_last", 128'(mem.MEM_RLAST), 128'(heldl));
      end else begin
        if (mem.MEM_RVALID) begin
          rbuf[n] = mem.MEM_RDATA;
          rlb[n]  = mem.MEM_RLAST;
          check_val("rresp", 128'(mem.MEM_RRESP), 128'(0));
          n++;
        end
        tick();
      end
      cyc++;
    end
    mem.MEM_RREADY = 1'b0;
    check_val("rd_beats", 128'(n), 128'(int'(len) + 1));
    check_val("rvalid_drop", 128'(mem.MEM_RVALID), 128'(0));
    check_val("arready_back", 128'(mem.MEM_ARREADY), 128'(1));
  endtask

  task automatic expect_beats(input string tag, input int len, input logic [127:0] e0,
                              input logic [127:0] e1, input logic [127:0] e2, input logic [127:0] e3);
    logic [127:0] ev [0:3];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    for (int i = 0; i <= len; i++) begin
      check_val($sformatf("%s_data%0d", tag, i), rbuf[i], ev[i]);
      check_val($sformatf("%s_last%0d", tag, i), 128'(rlb[i]), 128'(i == len));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    mem.MEM_AWADDR = 32'd0; mem.MEM_AWLEN = 8'd0; mem.MEM_AWSIZE = 3'd0; mem.MEM_AWBURST = 2'd0;
    mem.MEM_AWVALID = 1'b0; mem.MEM_WDATA = 128'd0; mem.MEM_WSTRB = 16'd0; mem.MEM_WLAST = 1'b0;
    mem.MEM_WVALID = 1'b0; mem.MEM_BREADY = 1'b0;
    mem.MEM_ARADDR = 32'd0; mem.MEM_ARLEN = 8'd0; mem.MEM_ARSIZE = 3'd0; mem.MEM_ARBURST = 2'd0;
    mem.MEM_ARVALID = 1'b0; mem.MEM_RREADY = 1'b0;
    dut.i_sram.ram[0]  = 128'h0123456789ABCDEF0123456789ABCDEF;
    dut.i_sram.ram[32] = {128{1'b1}};

    tick();
    tick();
    check_val("rst_awready", 128'(mem.MEM_AWREADY), 128'(0));
    check_val("rst_wready",  128'(mem.MEM_WREADY),  128'(0));
    check_val("rst_bvalid",  128'(mem.MEM_BVALID),  128'(0));
    check_val("rst_arready", 128'(mem.MEM_ARREADY), 128'(0));
    check_val("rst_rvalid",  128'(mem.MEM_RVALID),  128'(0));
    check_val("rst_rlast",   128'(mem.MEM_RLAST),   128'(0));
    check_val("rst_rdata",   mem.MEM_RDATA,         128'd0);
    reset = 1'b0;
    tick();
    check_val("idle_awready", 128'(mem.MEM_AWREADY), 128'(1));
    check_val("idle_arready", 128'(mem.MEM_ARREADY), 128'(1));
    check_val("idle_bvalid",  128'(mem.MEM_BVALID),  128'(0));
    check_val("idle_rvalid",  128'(mem.MEM_RVALID),  128'(0));

    // Single backdoor read, checked cycle by cycle
    mem.MEM_ARADDR = 32'h0; mem.MEM_ARLEN = 8'd0; mem.MEM_ARSIZE = 3'd4; mem.MEM_ARBURST = 2'd1;
    mem.MEM_ARVALID = 1'b1;
    tick();
    mem.MEM_ARVALID = 1'b0;
    check_val("single_rvalid",  128'(mem.MEM_RVALID),  128'(1));
    check_val("single_rdata",   mem.MEM_RDATA, 128'h0123456789ABCDEF0123456789ABCDEF);
    check_val("single_rlast",   128'(mem.MEM_RLAST),   128'(1));
    check_val("single_rresp",   128'(mem.MEM_RRESP),   128'(0));
    check_val("single_arready", 128'(mem.MEM_ARREADY), 128'(0));
    mem.MEM_RREADY = 1'b1;
    tick();
    mem.MEM_RREADY = 1'b0;
    check_val("single_rvalid_drop", 128'(mem.MEM_RVALID),  128'(0));
    check_val("single_arready_back", 128'(mem.MEM_ARREADY), 128'(1));

    // INCR write then read back
    for (int i = 0; i < 4; i++) wbuf[i] = 128'(i + 1);
    axi_write(32'h100, 8'd3, 16'hFFFF);
    axi_read(32'h100, 8'd3, 2'd1, 1'b0);
    expect_beats("incr", 3, 128'd1, 128'd2, 128'd3, 128'd4);

    // Partial strobe over an all-ones word, read under backpressure
    wbuf[0] = 128'd0;
    axi_write(32'h200, 8'd0, 16'h000F);
    axi_read(32'h200, 8'd0, 2'd1, 1'b1);
    expect_beats("strb", 0, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0}, 128'd0, 128'd0, 128'd0);
    axi_read(32'h100, 8'd1, 2'd1, 1'b1);
    expect_beats("bp", 1, 128'd1, 128'd2, 128'd0, 128'd0);

    // WRAP starting mid-window, FIXED repeating one word
    axi_read(32'h130, 8'd3, 2'd2, 1'b0);
    expect_beats("wrap", 3, 128'd4, 128'd1, 128'd2, 128'd3);
    axi_read(32'h100, 8'd2, 2'd0, 1'b0);
    expect_beats("fixed", 2, 128'd1, 128'd1, 128'd1, 128'd0);

    // Concurrent read and write to different words
    for (int i = 0; i < 4; i++) wbuf[i] = 128'hA0 + 128'(i);
    fork
      axi_write(32'h400, 8'd3, 16'hFFFF);
      axi_read(32'h100, 8'd3, 2'd1, 1'b0);
    join
    expect_beats("conc_rd", 3, 128'd1, 128'd2, 128'd3, 128'd4);
    axi_read(32'h400, 8'd3, 2'd1, 1'b0);
    expect_beats("conc_wr", 3, 128'hA0, 128'hA1, 128'hA2, 128'hA3);

    // Reset in the middle of a stalled read burst
    mem.MEM_ARADDR = 32'h400; mem.MEM_ARLEN = 8'd3; mem.MEM_ARBURST = 2'd1; mem.MEM_ARVALID = 1'b1;
    tick();
    mem.MEM_ARVALID = 1'b0;
    check_val("mid_rvalid", 128'(mem.MEM_RVALID), 128'(1));
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_rvalid",  128'(mem.MEM_RVALID),  128'(0));
    check_val("mid_rst_rdata",   mem.MEM_RDATA,         128'd0);
    check_val("mid_rst_arready", 128'(mem.MEM_ARREADY), 128'(0));
    tick();
    reset = 1'b0;
    tick();
    check_val("post_rst_arready", 128'(mem.MEM_ARREADY), 128'(1));
    axi_read(32'h410, 8'd0, 2'd1, 1'b0);
    expect_beats("post_rst", 0, 128'hA1, 128'd0, 128'd0, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
